ring_alloc_queue: RTL and testbench
===================================

Name: ring_alloc_queue

Overview:
- Circular allocate/retire queue with head/tail pointers for in-order structures (store-queue or branch-tag style).
- Supplies the start/end indices and enable/all-ones controls to the range-mask generator, which produces the per-entry valid mask.
- Supports one enqueue and one dequeue per cycle, plus a mispredict squash that truncates the tail back to a given allocated index, and a full flush.

Parameters:
LENGTH, 8, number of entries; power of two, ≥2
DATA_W, 32, payload width per entry
IDX_W, $clog2(LENGTH), entry index width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IN_enqValid  in  1  request to allocate one entry
IN_enqData  in  DATA_W  payload for the allocated entry
OUT_enqReady  out  1  queue not full
OUT_enqIdx  out  IDX_W+1  pointer handed to the allocated entry: {wrap, index}, equals current tail
IN_deqReady  in  1  consumer accepts the head entry
OUT_deqValid  out  1  head entry available
OUT_deqData  out  DATA_W  head entry payload
IN_squashValid  in  1  squash all entries from IN_squashIdx to tail
IN_squashIdx  in  IDX_W+1  first squashed pointer {wrap, index}
IN_flushAll  in  1  discard every entry
OUT_count  out  IDX_W+1  occupied entries, 0..LENGTH
OUT_validMask  out  LENGTH  bit i set iff entry i is occupied

Behaviour:
- State: head and tail, each IDX_W+1 bits with wrap MSB; payload RAM of LENGTH×DATA_W. Pointer arithmetic is modulo 2^(IDX_W+1).
- empty = (head == tail). full = index bits equal and wrap bits differ.
- count = tail − head (IDX_W+1 bits, unsigned).
- Reset:
  - head = tail = 0.
  - OUT_deqValid = 0, OUT_enqReady = 1, OUT_count = 0, OUT_validMask = 0.
  - RAM contents are not reset. OUT_deqData is don't-care while OUT_deqValid = 0.
- Enqueue fire = IN_enqValid & OUT_enqReady & !IN_squashValid & !IN_flushAll.
  - On fire: write RAM[tail.index] and increment tail.
  - The entry is visible to OUT_deqValid/OUT_validMask on the next cycle (1-cycle latency). No same-cycle bypass into an empty queue.
- OUT_enqReady = !full. It does not depend on dequeue in the same cycle, so there is no full-queue pass-through.
- Dequeue:
  - OUT_deqValid = !empty & !IN_flushAll & !(IN_squashValid & IN_squashIdx == head).
  - Fire = OUT_deqValid & IN_deqReady. On fire, head increments.
  - OUT_deqData = RAM[head.index], combinational read of registered state.
- Squash:
  - Legal iff IN_squashIdx lies in [head, tail] by ring distance, i.e. (IN_squashIdx − head) ≤ count.
  - Legal squash: next tail = IN_squashIdx; enqueue is suppressed.
  - Squash to tail is a legal no-op.
  - Illegal squash (target outside range) is ignored entirely; the enqueue is still suppressed that cycle. Verification flags it with an assertion.
  - Dequeue in the same cycle proceeds unless the head itself is squashed. If the squash target equals head, the queue becomes empty.
- IN_flushAll: next head = next tail = 0. Overrides squash, enqueue and dequeue.
- Priority: rst > IN_flushAll > squash > enqueue/dequeue.
- Full and dequeue simultaneously: only the dequeue fires. OUT_enqReady becomes 1 the next cycle.
- Empty and enqueue: tail advances; deqValid = 0 this cycle, 1 next.
- Wrap: the index wraps LENGTH−1→0 and toggles the wrap bit. Full and empty are both expressible.
- OUT_validMask comes from the range-mask generator:
  - start = head.index, end = tail.index, enable = !empty, allOnes = full.
  - Non-equal output (OUTPUT_ON_EQUAL = 0); no shifts.
  - The mask is combinational from registered pointers only, never from same-cycle inputs.
- OUT_count and OUT_enqIdx are combinational from registered pointers.

Decomposition:
- Shared package holds a parameterised pointer struct {logic wrap; logic[IDX_W-1:0] idx} and functions ptr_inc, ptr_dist (unsigned subtract), ptr_in_range.
- One sub-module: RangeMaskGen, instantiated as described above for OUT_validMask. The payload RAM is inferred inline.

Test Plan:
- Reset, then enqueue 8 values 0x10..0x17 on consecutive cycles (LENGTH = 8) → enqReady drops after the 8th, count = 8, validMask = 0xFF, enqIdx after = {1,0}; dequeue all → data 0x10..0x17 in order, then mask = 0x00.
- Wrap: enqueue 6, dequeue 4, enqueue 4 → head = {0,4}, tail = {1,2}, count = 6, validMask = 0b1111_0011.
- Squash: head = {0,1}, tail = {0,6}, squashIdx = {0,3} with enqValid = 1 → next tail = {0,3}, count = 2, mask = 0b0000_0110, no write occurred.
- Squash at head with deqReady = 1 → deqValid = 0 that cycle, queue empty next cycle, head unchanged.
- Full with deqReady & enqValid → only dequeue fires, count 8→7, enqReady = 1 next cycle. Illegal squashIdx {1,5} with head = {0,2}, tail = {0,4} → pointers unchanged.
- flushAll while squashValid, enqValid and deqReady are all high → head = tail = 0 next cycle, mask = 0, count = 0. Assert rst mid-stream → same outcome.

Source files
------------

// File: rtl/ring_alloc_queue_pkg.sv
// Shared pointer helpers for the ring allocate/retire queue.
// Pointers are {wrap, index}; arithmetic is modulo 2^width.
package ring_alloc_queue_pkg;

    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_raw_t;

    function automatic ptr_raw_t ptr_mask(input int w);
        ptr_raw_t one;
        one = ptr_raw_t'(1);
        return (one << w) - one;
    endfunction

    function automatic ptr_raw_t ptr_inc(input ptr_raw_t p, input int w);
        return (p + ptr_raw_t'(1)) & ptr_mask(w);
    endfunction

    function automatic ptr_raw_t ptr_dist(input ptr_raw_t a, input ptr_raw_t b,
                                          input int w);
        return (a - b) & ptr_mask(w);
    endfunction

    // True when x sits between head and tail inclusive, by ring distance.
    function automatic logic ptr_in_range(input ptr_raw_t x, input ptr_raw_t h,
                                          input ptr_raw_t t, input int w);
        return ptr_dist(x, h, w) <= ptr_dist(t, h, w);
    endfunction

endpackage

// File: rtl/ring_alloc_queue_range_mask.sv
// Circular range mask: sets bits in [start, end) with wrap-around.
// allOnes forces a full mask; equal bounds give OUTPUT_ON_EQUAL.
module RangeMaskGen #(
    parameter int LENGTH          = 8,
    parameter bit OUTPUT_ON_EQUAL = 1'b0,
    parameter int IDX_W           = $clog2(LENGTH)
) (
    input  logic [IDX_W-1:0]  i_start,
    input  logic [IDX_W-1:0]  i_end,
    input  logic              i_enable,
    input  logic              i_allOnes,
    output logic [LENGTH-1:0] o_mask
);

    always_comb begin
        o_mask = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (i_enable) begin
                if (i_allOnes) begin
                    o_mask[i] = 1'b1;
                end else if (i_start == i_end) begin
                    o_mask[i] = OUTPUT_ON_EQUAL;
                end else if (i_start < i_end) begin
                    o_mask[i] = (IDX_W'(i) >= i_start) && (IDX_W'(i) < i_end);
                end else begin
                    o_mask[i] = (IDX_W'(i) >= i_start) || (IDX_W'(i) < i_end);
                end
            end
        end
    end

endmodule

// File: rtl/ring_alloc_queue.sv
// Circular allocate/retire queue with squash-to-index and full flush.
// One enqueue and one dequeue per cycle; outputs derive from registered pointers.
module ring_alloc_queue
    import ring_alloc_queue_pkg::*;
#(
    parameter int LENGTH = 8,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_enqValid,
    input  logic [DATA_W-1:0] IN_enqData,
    output logic              OUT_enqReady,
    output logic [IDX_W:0]    OUT_enqIdx,
    input  logic              IN_deqReady,
    output logic              OUT_deqValid,
    output logic [DATA_W-1:0] OUT_deqData,
    input  logic              IN_squashValid,
    input  logic [IDX_W:0]    IN_squashIdx,
    input  logic              IN_flushAll,
    output logic [IDX_W:0]    OUT_count,
    output logic [LENGTH-1:0] OUT_validMask
);

    localparam int PW  = IDX_W + 1;
    localparam int PAD = PTR_MAX_W - PW;

    typedef struct packed {
        logic             wrap;
        logic [IDX_W-1:0] idx;
    } ptr_t;

    ptr_t              r_head;
    ptr_t              r_tail;
    logic [DATA_W-1:0] r_mem [LENGTH];

    ptr_raw_t w_head_raw;
    ptr_raw_t w_tail_raw;
    ptr_raw_t w_sq_raw;
    ptr_raw_t w_head_inc_raw;
    ptr_raw_t w_tail_inc_raw;
    ptr_t     w_head_inc;
    ptr_t     w_tail_inc;
    logic     w_empty;
    logic     w_full;
    logic     w_sq_head;
    logic     w_sq_legal;
    logic     w_enq_fire;
    logic     w_deq_fire;

    assign w_head_raw     = {{PAD{1'b0}}, r_head};
    assign w_tail_raw     = {{PAD{1'b0}}, r_tail};
    assign w_sq_raw       = {{PAD{1'b0}}, IN_squashIdx};
    assign w_head_inc_raw = ptr_inc(w_head_raw, PW);
    assign w_tail_inc_raw = ptr_inc(w_tail_raw, PW);
    assign w_head_inc     = ptr_t'(w_head_inc_raw[PW-1:0]);
    assign w_tail_inc     = ptr_t'(w_tail_inc_raw[PW-1:0]);

    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head.idx == r_tail.idx) && (r_head.wrap != r_tail.wrap);

    assign w_sq_head  = IN_squashValid && (IN_squashIdx == r_head);
    assign w_sq_legal = ptr_in_range(w_sq_raw, w_head_raw, w_tail_raw, PW);

    assign OUT_enqReady = !w_full;
    assign OUT_enqIdx   = r_tail;
    assign OUT_count    = r_tail - r_head;
    assign OUT_deqValid = !w_empty && !IN_flushAll && !w_sq_head;
    assign OUT_deqData  = r_mem[r_head.idx];

    assign w_enq_fire = IN_enqValid && !w_full && !IN_squashValid && !IN_flushAll;
    assign w_deq_fire = OUT_deqValid && IN_deqReady;

    always_ff @(posedge clk) begin
        if (rst || IN_flushAll) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_deq_fire) begin
                r_head <= w_head_inc;
            end
            // An out-of-range squash is dropped but still blocks the enqueue.
            if (IN_squashValid) begin
                if (w_sq_legal) begin
                    r_tail <= IN_squashIdx;
                end
            end else if (w_enq_fire) begin
                r_tail <= w_tail_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire && !rst) begin
            r_mem[r_tail.idx] <= IN_enqData;
        end
    end

    RangeMaskGen #(
        .LENGTH          (LENGTH),
        .OUTPUT_ON_EQUAL (1'b0)
    ) u_mask (
        .i_start   (r_head.idx),
        .i_end     (r_tail.idx),
        .i_enable  (!w_empty),
        .i_allOnes (w_full),
        .o_mask    (OUT_validMask)
    );

endmodule

// File: tb/tb_ring_alloc_queue.sv
// Randomised and directed bench for ring_alloc_queue.
// A queue-based model predicts every output on every cycle.
module tb_ring_alloc_queue;

    localparam int L  = 8;
    localparam int DW = 32;
    localparam int PM = 2 * L;

    logic          clk;
    logic          rst;
    logic          IN_enqValid;
    logic [DW-1:0] IN_enqData;
    logic          OUT_enqReady;
    logic [3:0]    OUT_enqIdx;
    logic          IN_deqReady;
    logic          OUT_deqValid;
    logic [DW-1:0] OUT_deqData;
    logic          IN_squashValid;
    logic [3:0]    IN_squashIdx;
    logic          IN_flushAll;
    logic [3:0]    OUT_count;
    logic [L-1:0]  OUT_validMask;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    int            mh = 0;

    ring_alloc_queue #(.LENGTH(L), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_enqValid    (IN_enqValid),
        .IN_enqData     (IN_enqData),
        .OUT_enqReady   (OUT_enqReady),
        .OUT_enqIdx     (OUT_enqIdx),
        .IN_deqReady    (IN_deqReady),
        .OUT_deqValid   (OUT_deqValid),
        .OUT_deqData    (OUT_deqData),
        .IN_squashValid (IN_squashValid),
        .IN_squashIdx   (IN_squashIdx),
        .IN_flushAll    (IN_flushAll),
        .OUT_count      (OUT_count),
        .OUT_validMask  (OUT_validMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare mid-cycle, advance the model, cross the edge.
    task automatic step(input bit r, input bit ev, input logic [DW-1:0] ed,
                        input bit dr, input bit sv, input logic [3:0] si,
                        input bit fl);
        int sz;
        int d;
        int ns;
        bit ev_ok;
        bit dfire;
        bit efire;
        logic [L-1:0] em;
        rst = r; IN_enqValid = ev; IN_enqData = ed; IN_deqReady = dr;
        IN_squashValid = sv; IN_squashIdx = si; IN_flushAll = fl;
        #4;
        sz = mq.size();
        em = '0;
        for (int k = 0; k < sz; k++) em[(mh + k) % L] = 1'b1;
        ev_ok = (sz != 0) && !fl && !(sv && int'(si) == mh);
        chk("enqReady", DW'(OUT_enqReady), DW'(sz < L));
        chk("enqIdx", DW'(OUT_enqIdx), DW'((mh + sz) % PM));
        chk("count", DW'(OUT_count), DW'(sz));
        chk("validMask", DW'(OUT_validMask), DW'(em));
        chk("deqValid", DW'(OUT_deqValid), DW'(ev_ok));
        if (ev_ok) chk("deqData", OUT_deqData, mq[0]);
        if (r || fl) begin
            mq.delete();
            mh = 0;
        end else begin
            dfire = ev_ok && dr;
            efire = ev && (sz < L) && !sv;
            d = (int'(si) - mh + PM) % PM;
            if (dfire) begin
                void'(mq.pop_front());
                mh = (mh + 1) % PM;
            end
            if (sv) begin
                if (d <= sz) begin
                    ns = d - (dfire ? 1 : 0);
                    while (mq.size() > ns) void'(mq.pop_back());
                end
            end else if (efire) begin
                mq.push_back(ed);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [DW-1:0] v);
        step(0, 1, v, 0, 0, 4'd0, 0);
    endtask

    task automatic deq();
        step(0, 0, 32'hx, 1, 0, 4'd0, 0);
    endtask

    task automatic do_rst();
        step(1, 0, 32'h0, 0, 0, 4'd0, 0);
    endtask

    initial begin
        int sz;
        logic [3:0] si;
        rst = 1; IN_enqValid = 0; IN_enqData = '0; IN_deqReady = 0;
        IN_squashValid = 0; IN_squashIdx = '0; IN_flushAll = 0;
        @(posedge clk);
        #1;
        do_rst();
        chk("rst_count", DW'(OUT_count), 32'd0);
        chk("rst_ready", DW'(OUT_enqReady), 32'd1);
        chk("rst_valid", DW'(OUT_deqValid), 32'd0);

        for (int i = 0; i < 8; i++) enq(32'h10 + 32'(i));
        chk("full_ready", DW'(OUT_enqReady), 32'd0);
        chk("full_count", DW'(OUT_count), 32'd8);
        chk("full_mask", DW'(OUT_validMask), 32'hFF);
        chk("full_idx", DW'(OUT_enqIdx), 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk("fifo_data", OUT_deqData, 32'h10 + 32'(i));
            deq();
        end
        chk("drain_mask", DW'(OUT_validMask), 32'h0);

        do_rst();
        for (int i = 0; i < 6; i++) enq(32'h20 + 32'(i));
        for (int i = 0; i < 4; i++) deq();
        for (int i = 0; i < 4; i++) enq(32'h30 + 32'(i));
        chk("wrap_tail", DW'(OUT_enqIdx), 32'hA);
        chk("wrap_count", DW'(OUT_count), 32'd6);
        chk("wrap_mask", DW'(OUT_validMask), 32'hF3);

        do_rst();
        for (int i = 0; i < 6; i++) enq(32'h40 + 32'(i));
        deq();
        step(0, 1, 32'hDEAD, 0, 1, 4'd3, 0);
        chk("sq_tail", DW'(OUT_enqIdx), 32'h3);
        chk("sq_count", DW'(OUT_count), 32'd2);
        chk("sq_mask", DW'(OUT_validMask), 32'h06);
        enq(32'h55);
        deq();
        deq();
        chk("sq_nowrite", OUT_deqData, 32'h55);

        do_rst();
        for (int i = 0; i < 3; i++) enq(32'h60 + 32'(i));
        deq();
        step(0, 0, 32'h0, 1, 1, 4'd1, 0);
        chk("sqh_count", DW'(OUT_count), 32'd0);
        chk("sqh_head", DW'(OUT_enqIdx), 32'h1);

        do_rst();
        for (int i = 0; i < 8; i++) enq(32'h70 + 32'(i));
        step(0, 1, 32'hBEEF, 1, 0, 4'd0, 0);
        chk("fd_count", DW'(OUT_count), 32'd7);
        chk("fd_ready", DW'(OUT_enqReady), 32'd1);

        do_rst();
        for (int i = 0; i < 4; i++) enq(32'h80 + 32'(i));
        deq();
        deq();
        step(0, 1, 32'h1, 0, 1, 4'hD, 0);
        chk("ill_count", DW'(OUT_count), 32'd2);
        chk("ill_tail", DW'(OUT_enqIdx), 32'h4);

        enq(32'h90);
        enq(32'h91);
        step(0, 1, 32'h2, 1, 1, 4'd3, 1);
        chk("fl_count", DW'(OUT_count), 32'd0);
        chk("fl_mask", DW'(OUT_validMask), 32'h0);
        chk("fl_idx", DW'(OUT_enqIdx), 32'h0);
        enq(32'hA0);
        enq(32'hA1);
        step(1, 1, 32'h3, 1, 0, 4'd0, 0);
        chk("rs_count", DW'(OUT_count), 32'd0);
        chk("rs_idx", DW'(OUT_enqIdx), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            sz = mq.size();
            if ($urandom_range(0, 1) == 0)
                si = 4'((mh + $urandom_range(0, sz)) % PM);
            else
                si = 4'($urandom_range(0, PM - 1));
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom,
                 $urandom_range(0, 9) < 5,
                 $urandom_range(0, 11) == 0,
                 si,
                 $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
